// File: rtl/coeff_seq.sv
// coeff_seq: multi-channel coefficient-ROM read sequencer.
//
// Holds one read pointer per channel and shares a single synchronous
// coefficient-memory read port between the channels through a round-robin
// arbiter. Each pointer advances under a shared per-entry advance mask. An
// optional per-entry hold count repeats reads of an entry. At the final
// entry the pointer either wraps to 0 or stops and raises a sticky done flag.
//
// Optional feature macro: COEFF_SEQ_STALL_CNT_EN
//   When defined, adds stall_cnt_o. It holds one saturating 16-bit counter
//   per channel, counting cycles where the channel is eligible but not granted.
//
// Ports:
//   clkn_i      clock, all state on posedge
//   rst_i       asynchronous reset, active high
//   redo_i      per-channel restart (pointer, hold count, done cleared)
//   rd_en_i     per-channel read request, level
//   adv_mask_i  per-entry advance enable (0 parks the pointer on that entry)
//   last_ptr_i  final entry index, shared by all channels
//   wrap_en_i   1: wrap to 0 after last entry, 0: stop and flag done
//   hold_i      extra reads per entry before advancing
//   gnt_o       one-hot combinational grant
//   mem_re_o    registered memory read enable
//   mem_addr_o  registered {channel, pointer}
//   rd_vld_o    read data valid, aligned to sync-RAM output
//   rd_ch_o     channel owning the data flagged by rd_vld_o
//   rd_ptr_o    current pointer per channel, channel c at [c*ADDR_LINES +: ADDR_LINES]
//   done_o      per-channel end-of-table flag
//   stall_cnt_o per-channel stall counters (COEFF_SEQ_STALL_CNT_EN only)

module coeff_seq #(
  parameter int ADDR_LINES = 4,
  parameter int CHANNELS   = 2,
  parameter int CH_W       = $clog2(CHANNELS),
  parameter int HOLD_W     = 4
) (
  input  logic                           clkn_i,
  input  logic                           rst_i,
  input  logic [CHANNELS-1:0]            redo_i,
  input  logic [CHANNELS-1:0]            rd_en_i,
  input  logic [(1<<ADDR_LINES)-1:0]     adv_mask_i,
  input  logic [ADDR_LINES-1:0]          last_ptr_i,
  input  logic                           wrap_en_i,
  input  logic [HOLD_W-1:0]              hold_i,
  output logic [CHANNELS-1:0]            gnt_o,
  output logic                           mem_re_o,
  output logic [CH_W+ADDR_LINES-1:0]     mem_addr_o,
  output logic                           rd_vld_o,
  output logic [CH_W-1:0]                rd_ch_o,
  output logic [CHANNELS*ADDR_LINES-1:0] rd_ptr_o,
`ifdef COEFF_SEQ_STALL_CNT_EN
  output logic [CHANNELS*16-1:0]         stall_cnt_o,
`endif
  output logic [CHANNELS-1:0]            done_o
);

  logic [ADDR_LINES-1:0] ptr_q  [CHANNELS];
  logic [HOLD_W-1:0]     hold_q [CHANNELS];
  logic [CHANNELS-1:0]   done_q;
  logic [CH_W-1:0]       last_q;

  logic [CHANNELS-1:0]   elig;
  logic                  gnt_any;
  logic [CH_W-1:0]       gnt_idx;
  logic [CH_W-1:0]       cand;

  assign elig = rd_en_i & ~done_q & ~redo_i;

  // Search starts one past the last granted channel. CHANNELS is a power of
  // two, so the CH_W-bit sum wraps around the channel ring by itself; the
  // final step (k == CHANNELS) revisits the last granted channel.
  always_comb begin
    gnt_o   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      cand = last_q + CH_W'(k);
      if (!gnt_any && elig[cand]) begin
        gnt_any       = 1'b1;
        gnt_idx       = cand;
        gnt_o[cand]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clkn_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= CH_W'(CHANNELS - 1);
    end else if (gnt_any) begin
      last_q <= gnt_idx;
    end
  end

  // Per-channel pointer / hold / done. redo wins over a grant; the arbiter
  // already excludes redo channels, so the grant branch never sees one.
  always_ff @(posedge clkn_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        ptr_q[c]  <= '0;
        hold_q[c] <= '0;
      end
      done_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (redo_i[c]) begin
          ptr_q[c]  <= '0;
          hold_q[c] <= '0;
          done_q[c] <= 1'b0;
        end else if (gnt_o[c] && adv_mask_i[ptr_q[c]]) begin
          // A count already above a lowered hold_i counts as expired.
          if (hold_q[c] < hold_i) begin
            hold_q[c] <= hold_q[c] + 1'b1;
          end else begin
            hold_q[c] <= '0;
            if (ptr_q[c] != last_ptr_i) begin
              ptr_q[c] <= ptr_q[c] + 1'b1;
            end else if (wrap_en_i) begin
              ptr_q[c] <= '0;
            end else begin
              done_q[c] <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Read pipeline: grant -> address register -> data valid. In-flight reads
  // finish regardless of redo; only reset flushes them.
  always_ff @(posedge clkn_i or posedge rst_i) begin
    if (rst_i) begin
      mem_re_o   <= 1'b0;
      mem_addr_o <= '0;
      rd_vld_o   <= 1'b0;
      rd_ch_o    <= '0;
    end else begin
      mem_re_o <= gnt_any;
      if (gnt_any) begin
        mem_addr_o <= {gnt_idx, ptr_q[gnt_idx]};
      end
      rd_vld_o <= mem_re_o;
      rd_ch_o  <= mem_addr_o[ADDR_LINES +: CH_W];
    end
  end

  always_comb begin
    rd_ptr_o = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      rd_ptr_o[c*ADDR_LINES +: ADDR_LINES] = ptr_q[c];
    end
  end

  assign done_o = done_q;

`ifdef COEFF_SEQ_STALL_CNT_EN
  logic [15:0] stall_q [CHANNELS];

  always_ff @(posedge clkn_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        stall_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (redo_i[c]) begin
          stall_q[c] <= '0;
        end else if (elig[c] && !gnt_o[c] && stall_q[c] != 16'hFFFF) begin
          stall_q[c] <= stall_q[c] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_o = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      stall_cnt_o[c*16 +: 16] = stall_q[c];
    end
  end
`endif

endmodule

// File: tb/tb_coeff_seq.sv
module tb_coeff_seq;
  localparam int AL  = 4;
  localparam int CH  = 2;
  localparam int CHW = 1;
  localparam int HW  = 4;
  localparam int NE  = 1 << AL;

  logic             clk;
  logic             rst;
  logic [CH-1:0]    redo;
  logic [CH-1:0]    rd_en;
  logic [NE-1:0]    mask;
  logic [AL-1:0]    last_ptr;
  logic             wrap_en;
  logic [HW-1:0]    hold;
  logic [CH-1:0]    gnt_o;
  logic             mem_re_o;
  logic [CHW+AL-1:0] mem_addr_o;
  logic             rd_vld_o;
  logic [CHW-1:0]   rd_ch_o;
  logic [CH*AL-1:0] rd_ptr_o;
  logic [CH-1:0]    done_o;
`ifdef COEFF_SEQ_STALL_CNT_EN
  logic [CH*16-1:0] stall_cnt_o;
`endif

  coeff_seq #(.ADDR_LINES(AL), .CHANNELS(CH), .HOLD_W(HW)) dut (
    .clkn_i(clk), .rst_i(rst), .redo_i(redo), .rd_en_i(rd_en),
    .adv_mask_i(mask), .last_ptr_i(last_ptr), .wrap_en_i(wrap_en),
    .hold_i(hold), .gnt_o(gnt_o), .mem_re_o(mem_re_o),
    .mem_addr_o(mem_addr_o), .rd_vld_o(rd_vld_o), .rd_ch_o(rd_ch_o),
    .rd_ptr_o(rd_ptr_o),
`ifdef COEFF_SEQ_STALL_CNT_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int addr_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer pointers per channel, a ring search for the
  // grant, and a two-deep pipeline of expected read-port activity.
  int  mptr[CH], mhold[CH], mstall[CH];
  bit  mdone[CH];
  int  mlast;
  bit  exp_re, exp_vld;
  int  exp_ach, exp_aptr, exp_rch;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      mptr[c] = 0; mhold[c] = 0; mdone[c] = 0; mstall[c] = 0;
    end
    mlast = CH - 1;
    exp_re = 0; exp_vld = 0; exp_ach = 0; exp_aptr = 0; exp_rch = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    int g;
    bit el[CH];
    if (rst) begin
      model_reset();
      chk("rst_mem_re", mem_re_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_rd_vld", rd_vld_o, 0);
      chk("rst_rd_ch", rd_ch_o, 0);
      chk("rst_rd_ptr", rd_ptr_o, 0);
      chk("rst_done", done_o, 0);
    end else begin
      g = -1;
      for (int c = 0; c < CH; c++) el[c] = rd_en[c] && !mdone[c] && !redo[c];
      for (int k = 1; k <= CH; k++) begin
        if (g < 0 && el[(mlast + k) % CH]) g = (mlast + k) % CH;
      end
      chk("gnt", gnt_o, (g >= 0) ? (1 << g) : 0);
      chk("mem_re", mem_re_o, exp_re);
      if (exp_re) chk("mem_addr", mem_addr_o, exp_ach * NE + exp_aptr);
      chk("rd_vld", rd_vld_o, exp_vld);
      if (exp_vld) chk("rd_ch", rd_ch_o, exp_rch);
      for (int c = 0; c < CH; c++) begin
        chk("rd_ptr", rd_ptr_o[c*AL +: AL], mptr[c]);
        chk("done", done_o[c], mdone[c]);
`ifdef COEFF_SEQ_STALL_CNT_EN
        chk("stall_cnt", stall_cnt_o[c*16 +: 16], mstall[c]);
`endif
      end
      if (mem_re_o) addr_log.push_back(int'(mem_addr_o));

      exp_vld = exp_re;
      exp_rch = exp_ach;
      exp_re  = (g >= 0);
      if (g >= 0) begin
        exp_ach  = g;
        exp_aptr = mptr[g];
        mlast    = g;
      end
      for (int c = 0; c < CH; c++) begin
        if (redo[c]) begin
          mptr[c] = 0; mhold[c] = 0; mdone[c] = 0; mstall[c] = 0;
        end else begin
          if (el[c] && c != g && mstall[c] < 65535) mstall[c]++;
          if (c == g && mask[mptr[c]]) begin
            if (mhold[c] < int'(hold)) mhold[c]++;
            else begin
              mhold[c] = 0;
              if (mptr[c] != int'(last_ptr)) mptr[c] = (mptr[c] + 1) % NE;
              else if (wrap_en) mptr[c] = 0;
              else mdone[c] = 1;
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; rd_en = '0; redo = '0;
    repeat (2) @(posedge clk);
    #1;
    addr_log.delete();
    rst = 1'b0;
  endtask

  task automatic chk_log(input string name, input int exp[]);
    chk({name, "_len"}, (addr_log.size() >= exp.size()), 1);
    for (int i = 0; i < exp.size(); i++) begin
      if (i < addr_log.size()) chk(name, addr_log[i], exp[i]);
    end
  endtask

  initial begin
    rst = 1'b1; redo = '0; rd_en = '0; mask = '1;
    last_ptr = 4'd3; wrap_en = 1'b0; hold = '0;
    repeat (3) @(posedge clk);

    // single channel, stop at last entry
    mask = '1; hold = 0; last_ptr = 3; wrap_en = 0;
    do_reset();
    rd_en = 2'b01;
    repeat (8) @(posedge clk);
    #1;
    chk("s1_log_size", addr_log.size(), 4);
    chk_log("s1_addr", '{0, 1, 2, 3});
    chk("s1_done", done_o, 2'b01);

    // two channels alternating, wrap at 1
    wrap_en = 1; last_ptr = 1;
    do_reset();
    rd_en = 2'b11;
    repeat (6) @(posedge clk);
    #1;
    chk_log("s2_addr", '{0, 16, 1, 17, 0});

    // hold of 2
    hold = 2; last_ptr = 15; wrap_en = 1;
    do_reset();
    rd_en = 2'b01;
    repeat (7) @(posedge clk);
    #1;
    chk_log("s3_addr", '{0, 0, 0, 1, 1, 1});

    // parking on masked entry
    hold = 0; mask = 16'h0003; wrap_en = 0;
    do_reset();
    rd_en = 2'b01;
    repeat (8) @(posedge clk);
    #1;
    chk_log("s4_addr", '{0, 1, 2, 2, 2});
    chk("s4_done", done_o, 0);
    chk("s4_ptr", rd_ptr_o[AL-1:0], 2);

    // redo while requesting
    mask = '1; wrap_en = 1;
    do_reset();
    rd_en = 2'b01;
    repeat (5) @(posedge clk);
    #1;
    chk("s5_ptr5", rd_ptr_o[AL-1:0], 5);
    redo = 2'b01; rd_en = 2'b11;
    @(negedge clk);
    chk("s5_gnt", gnt_o, 2'b10);
    @(posedge clk); #1;
    redo = 2'b00;
    chk("s5_ptr0", rd_ptr_o[AL-1:0], 0);

    // reset during an active read
    do_reset();
    rd_en = 2'b01;
    @(posedge clk); #1;
    chk("s6_re_before", mem_re_o, 1);
    rd_en = 2'b00;
    rst = 1'b1;
    #1;
    chk("s6_re", mem_re_o, 0);
    chk("s6_addr", mem_addr_o, 0);
    chk("s6_vld", rd_vld_o, 0);
    chk("s6_ptr", rd_ptr_o, 0);
`ifdef COEFF_SEQ_STALL_CNT_EN
    chk("s6_stall", stall_cnt_o, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("s6_vld_after", rd_vld_o, 0);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) begin
        mask     = ($urandom_range(0, 2) == 0) ? NE'($urandom) : '1;
        last_ptr = AL'($urandom);
        wrap_en  = 1'($urandom);
        hold     = HW'($urandom_range(0, 3));
      end
      rd_en = CH'($urandom);
      redo  = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
      @(posedge clk); #1;
    end
    redo = '0; rd_en = '0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/coeff_seq.md
Name: coeff_seq

Overview:
Parametrised, multi-channel successor to the coefficient read-pointer counter. It holds one coefficient-ROM read pointer per approximation channel and advances each pointer under a shared segment-advance mask. It adds a per-entry hold count, wrap/stop end modes and a done flag. A round-robin arbiter shares a single synchronous coefficient-memory read port between all channels. It sits between the per-channel evaluation pipelines of the nonlinear approximation engine and the shared coefficient memory.

Parameters:
ADDR_LINES, 4, pointer width; each channel addresses 2^ADDR_LINES coefficient entries
CHANNELS, 2, number of channels; must be a power of two, >= 2
CH_W, $clog2(CHANNELS), channel index width (derived, do not override)
HOLD_W, 4, width of the per-entry hold count

Ports:
clkn_i  in  1  clock; all state updates on posedge clkn_i
rst_i  in  1  asynchronous reset, active high
redo_i  in  CHANNELS  per-channel restart: clears pointer, hold count and done
rd_en_i  in  CHANNELS  per-channel read request; level, held until granted
adv_mask_i  in  2^ADDR_LINES  bit k=1: entry k may advance; 0: pointer parks on entry k
last_ptr_i  in  ADDR_LINES  final entry index; shared by all channels
wrap_en_i  in  1  1: wrap to 0 after last_ptr_i; 0: stop and flag done
hold_i  in  HOLD_W  extra reads per entry before advance (0 = advance every read)
gnt_o  out  CHANNELS  one-hot combinational grant for the current cycle
mem_re_o  out  1  registered memory read enable
mem_addr_o  out  CH_W+ADDR_LINES  registered {channel, pointer}
rd_vld_o  out  1  read data valid; aligned to sync-RAM output
rd_ch_o  out  CH_W  channel owning the data flagged by rd_vld_o
rd_ptr_o  out  CHANNELS*ADDR_LINES  current pointer per channel; channel c at [c*ADDR_LINES +: ADDR_LINES]
done_o  out  CHANNELS  per-channel end-of-table flag

Behaviour:
- Reset: all pointers 0, hold counters 0, done_o 0, mem_re_o 0, mem_addr_o 0, rd_vld_o 0, rd_ch_o 0, arbiter last-grant = CHANNELS-1, so channel 0 has first priority.
- Eligible channel c: rd_en_i[c] & ~done_o[c] & ~redo_i[c].
- Arbiter: at most one grant per cycle. Round-robin starts at the channel after the last granted channel. The last-grant register updates only when a grant is issued.
- Grant to channel c at cycle N:
  - mem_re_o=1 and mem_addr_o={c, ptr[c] before update} from N+1.
  - rd_vld_o=1 and rd_ch_o=c from N+2.
  - Without a grant, mem_re_o=0 on the next cycle; rd_vld_o follows mem_re_o with one cycle of delay.
- Pointer update on grant:
  - adv_mask_i[ptr]=0: pointer and hold counter unchanged.
  - mask=1 and hold_cnt<hold_i: hold_cnt+1, pointer unchanged.
  - mask=1 and hold_cnt>=hold_i: hold_cnt cleared, then:
    - ptr!=last_ptr_i: ptr+1.
    - ptr==last_ptr_i and wrap_en_i=1: ptr=0.
    - ptr==last_ptr_i and wrap_en_i=0: ptr unchanged, done set.
- Pointer increment is modulo 2^ADDR_LINES. If last_ptr_i is never reached, the pointer wraps naturally at 2^ADDR_LINES-1 to 0.
- done_o[c] is sticky. It blocks further grants to c and clears only on redo_i[c] or reset.
- redo_i[c] has priority over everything for channel c in the same cycle: c is not granted, and next state is ptr=0, hold=0, done=0. Other channels are arbitrated normally.
- Reads already in flight (mem_re_o / rd_vld_o pipeline) always complete, even across redo.
- Changing hold_i mid-entry takes effect on the next grant. A hold_cnt above the new hold_i counts as expired.
- Asynchronous reset mid-operation drops all in-flight reads; no rd_vld_o is produced for them.

Optional Feature:
COEFF_SEQ_STALL_CNT_EN
- Defined: adds output stall_cnt_o [CHANNELS*16], one 16-bit counter per channel.
  - Counts cycles where the channel is eligible but not granted.
  - Saturates at 16'hFFFF.
  - Cleared by reset or redo_i[c].
- Undefined: no port and no counter logic. Behaviour is otherwise identical.

Test Plan:
- Reset, then CHANNELS=2, rd_en_i=2'b01, mask all 1, hold_i=0, last_ptr_i=3, wrap_en_i=0 -> mem_addr_o 0,1,2,3 on consecutive cycles; done_o[0]=1 after the fourth grant; no further mem_re_o; rd_vld_o trails mem_re_o by one cycle.
- rd_en_i=2'b11 continuously, wrap_en_i=1, last_ptr_i=1 -> gnt_o alternates 01,10,01,...; mem_addr_o sequence {0,0},{1,0},{0,1},{1,1},{0,0}; each pointer wraps 1->0.
- hold_i=2, mask all 1, single channel -> each pointer value issued 3 times (0,0,0,1,1,1,...) before advancing.
- adv_mask_i=16'h0003, hold_i=0 -> pointer goes 0,1,2 then parks at 2 indefinitely while granted; done_o stays 0.
- Channel 0 at ptr=5 with redo_i[0] and rd_en_i[0] high in the same cycle -> no grant to channel 0 that cycle; rd_ptr_o[0]=0 next cycle; channel 1 is still granted if requesting.
- Assert rst_i while mem_re_o=1 -> all outputs 0 immediately; rd_vld_o stays 0 the following cycle; with COEFF_SEQ_STALL_CNT_EN defined, stall_cnt_o=0.
